// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } bcd_state_e;

    // ceil(width * log10(2)) in integer arithmetic.
    function automatic int unsigned bcd_digits_for(int unsigned width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/done handshake and result bus between a requester and bin_to_bcd_seq.
interface bin_to_bcd_seq_if #(
    parameter int unsigned BIN_W  = 32,
    parameter int unsigned DIGITS = bcd_pkg::bcd_digits_for(BIN_W)
);
    import bcd_pkg::*;

    logic                      start;
    logic [BIN_W-1:0]          bin_in;
    logic                      ready;
    logic                      busy;
    logic                      done;
    logic [BCD_W*DIGITS-1:0]   bcd_out;
    logic [DIGITS-1:0]         blank;
    logic                      overflow;

    modport master (
        output start, bin_in,
        input  ready, busy, done, bcd_out, blank, overflow
    );

    modport slave (
        input  start, bin_in,
        output ready, busy, done, bcd_out, blank, overflow
    );

endinterface

// File: rtl/bcd_add3.sv
// One double-dabble correction cell: adds 3 to a BCD digit of 5 or more.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    assign dout = (din >= BCD_W'(5)) ? din + BCD_W'(3) : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock, registered result,
// overflow flag and leading-zero blank mask.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W  = 32,
    parameter int unsigned DIGITS = bcd_pkg::bcd_digits_for(BIN_W)
) (
    input logic             clk,
    input logic             rst,
    bin_to_bcd_seq_if.slave bus
);
    import bcd_pkg::*;

    localparam int unsigned BCD_TOT = BCD_W * DIGITS;
    localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    bcd_state_e          state_q, state_d;
    logic [BIN_W-1:0]    shift_q;
    logic [BCD_TOT-1:0]  bcd_q;
    logic [BCD_TOT-1:0]  bcd_adj;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_q;

    logic [BCD_TOT-1:0]  bcd_out_q;
    logic [DIGITS-1:0]   blank_q;
    logic                overflow_q;
    logic                done_q;

    logic                ready;
    logic                load;
    logic                do_shift;
    logic                finish;
    logic [DIGITS-1:0]   blank_mask;
    logic                upper_zero;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (bcd_q[g*BCD_W +: BCD_W]),
            .dout (bcd_adj[g*BCD_W +: BCD_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StShift;
            StShift: if (cnt_q == CNT_W'(1)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready    = (state_q == StIdle);
        load     = (state_q == StIdle) && bus.start;
        do_shift = (state_q == StShift);
        finish   = (state_q == StDone);
    end

    // Digit k is blank when it and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        blank_mask = '0;
        upper_zero = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            upper_zero    = upper_zero && (bcd_q[k*BCD_W +: BCD_W] == '0);
            blank_mask[k] = upper_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            bcd_out_q  <= '0;
            blank_q    <= BLANK_RST;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= finish;
            if (load) begin
                shift_q <= bus.bin_in;
                bcd_q   <= '0;
                cnt_q   <= CNT_W'(BIN_W);
                ovf_q   <= 1'b0;
            end else if (do_shift) begin
                shift_q <= shift_q << 1;
                bcd_q   <= {bcd_adj[BCD_TOT-2:0], shift_q[BIN_W-1]};
                cnt_q   <= cnt_q - CNT_W'(1);
                // A bit leaving the top digit means the value no longer fits.
                if (bcd_adj[BCD_TOT-1]) ovf_q <= 1'b1;
            end
            if (finish) begin
                bcd_out_q  <= bcd_q;
                blank_q    <= blank_mask;
                overflow_q <= ovf_q;
            end
        end
    end

    assign bus.ready    = ready;
    assign bus.busy     = ~ready;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_out_q;
    assign bus.blank    = blank_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: a 32-bit/10-digit and a 16-bit/4-digit instance.
module tb_bin_to_bcd_seq;

    typedef struct {
        logic [79:0] bcd;
        logic [19:0] blank;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    logic prev_done_a = 1'b0;
    logic prev_done_b = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bin_to_bcd_seq_if #(.BIN_W(32), .DIGITS(10)) bus_a ();
    bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(4))  bus_b ();

    bin_to_bcd_seq #(.BIN_W(32), .DIGITS(10)) u_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4))  u_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    function automatic void check(string name, logic [79:0] got, logic [79:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endfunction

    // Decimal digits by repeated division; whatever remains above DIGITS is overflow.
    function automatic exp_t model(input longint unsigned v, input int nd, input int c);
        exp_t            e;
        longint unsigned t = v;
        int              dig[20];
        bit              z = 1'b1;
        e.bcd   = '0;
        e.blank = '0;
        e.cyc   = c;
        for (int k = 0; k < nd; k++) begin
            dig[k] = int'(t % 10);
            t      = t / 10;
            e.bcd[4*k +: 4] = 4'(dig[k]);
        end
        e.ovf = (t != 0);
        for (int k = nd - 1; k >= 1; k--) begin
            z = z && (dig[k] == 0);
            e.blank[k] = z;
        end
        return e;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic convert_a(input logic [31:0] v);
        int n = 0;
        while (!bus_a.ready && n < 200) begin
            step(1);
            n++;
        end
        if (!bus_a.ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL a_ready_timeout: ready=0, expected 1");
            return;
        end
        bus_a.bin_in = v;
        bus_a.start  = 1'b1;
        q_a.push_back(model(64'(v), 10, cyc));
        step(1);
        bus_a.start  = 1'b0;
        bus_a.bin_in = $urandom;
    endtask

    task automatic convert_b(input logic [15:0] v);
        int n = 0;
        while (!bus_b.ready && n < 200) begin
            step(1);
            n++;
        end
        if (!bus_b.ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL b_ready_timeout: ready=0, expected 1");
            return;
        end
        bus_b.bin_in = v;
        bus_b.start  = 1'b1;
        q_b.push_back(model(64'(v), 4, cyc));
        step(1);
        bus_b.start  = 1'b0;
        bus_b.bin_in = 16'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 500) begin
            step(1);
            n++;
        end
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: pending a=%0d b=%0d, expected 0", q_a.size(), q_b.size());
        end
    endtask

    task automatic check_reset_a(string tag);
        @(negedge clk);
        check({tag, "_ready"}, 80'(bus_a.ready), 80'(1));
        check({tag, "_busy"}, 80'(bus_a.busy), 80'(0));
        check({tag, "_done"}, 80'(bus_a.done), 80'(0));
        check({tag, "_bcd"}, 80'(bus_a.bcd_out), 80'(0));
        check({tag, "_blank"}, 80'(bus_a.blank), 80'(10'b1111111110));
        check({tag, "_ovf"}, 80'(bus_a.overflow), 80'(0));
    endtask

    always @(negedge clk) begin
        if (bus_a.done) begin
            check("a_done_width", 80'(prev_done_a), 80'(0));
            if (q_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_unexpected_done: done=1 with nothing outstanding");
            end else begin
                ea = q_a.pop_front();
                check("a_bcd", 80'(bus_a.bcd_out), ea.bcd);
                check("a_blank", 80'(bus_a.blank), 80'(ea.blank[9:0]));
                check("a_ovf", 80'(bus_a.overflow), 80'(ea.ovf));
                check("a_latency", 80'(cyc - ea.cyc), 80'(34));
            end
        end
        prev_done_a = bus_a.done;
    end

    always @(negedge clk) begin
        if (bus_b.done) begin
            check("b_done_width", 80'(prev_done_b), 80'(0));
            if (q_b.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_unexpected_done: done=1 with nothing outstanding");
            end else begin
                eb = q_b.pop_front();
                check("b_bcd", 80'(bus_b.bcd_out), eb.bcd);
                check("b_blank", 80'(bus_b.blank), 80'(eb.blank[3:0]));
                check("b_ovf", 80'(bus_b.overflow), 80'(eb.ovf));
                check("b_latency", 80'(cyc - eb.cyc), 80'(18));
            end
        end
        prev_done_b = bus_b.done;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.start = 1'b0;
        bus_a.bin_in = '0;
        bus_b.start = 1'b0;
        bus_b.bin_in = '0;
        step(3);
        check_reset_a("a_rst");
        check("b_rst_blank", 80'(bus_b.blank), 80'(4'b1110));
        check("b_rst_ready", 80'(bus_b.ready), 80'(1));
        check("b_rst_bcd", 80'(bus_b.bcd_out), 80'(0));
        step(1);
        rst_a = 1'b0;
        rst_b = 1'b0;

        convert_a(32'd0);
        convert_a(32'hFFFF_FFFF);
        convert_a(32'd12345);
        convert_b(16'd65535);
        convert_b(16'd9999);
        for (int i = 0; i < 6; i++) begin
            convert_a($urandom);
            convert_a(32'($urandom_range(0, 999)));
            convert_b(16'($urandom_range(0, 65535)));
        end
        drain();

        // Second starts mid-shift and in the final state must both be dropped.
        convert_a(32'd987654321);
        step(5);
        bus_a.bin_in = 32'd111;
        bus_a.start  = 1'b1;
        step(1);
        bus_a.start  = 1'b0;
        step(26);
        bus_a.bin_in = 32'd222;
        bus_a.start  = 1'b1;
        step(1);
        bus_a.start  = 1'b0;
        step(40);
        check("a_ignored_idle", 80'(bus_a.ready), 80'(1));
        check("a_ignored_pending", 80'(q_a.size()), 80'(0));

        // Abort a conversion with reset on its tenth clock.
        convert_a(32'd55555);
        step(8);
        rst_a = 1'b1;
        step(1);
        rst_a = 1'b0;
        q_a.delete();
        check_reset_a("a_abort");
        step(40);
        check("a_abort_blank", 80'(bus_a.blank), 80'(10'b1111111110));

        convert_a(32'd4000000000);
        convert_b(16'd10000);
        drain();
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
